// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and reflected-Gray helpers for the 4-bit sequence generator and checker
package seq_gen_pkg;
  localparam int WORD_W = 4;
  typedef enum logic [1:0] {HUNT, TRACK, LOCKED, SLIP} state_e;
  function automatic logic [WORD_W-1:0] gray2bin(input logic [WORD_W-1:0] g);
    logic [WORD_W-1:0] b;
    b[WORD_W-1] = g[WORD_W-1];
    for (int i = WORD_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [WORD_W-1:0] bin2gray(input logic [WORD_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [WORD_W-1:0] gray_step(input logic [WORD_W-1:0] r, input logic dir);
    logic [WORD_W-1:0] b;
    b = gray2bin(r);
    return bin2gray(dir ? b - WORD_W'(1) : b + WORD_W'(1));
  endfunction
endpackage

// File: rtl/seq_check4bit.sv
// seq_check4bit: locks onto the generator's Gray sequence, flags and counts slips, drops lock on repeated errors
module seq_check4bit
  import seq_gen_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_ERR = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             w,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);
  localparam logic [3:0] LOCK_C  = 4'(LOCK_CNT);
  localparam logic [3:0] UNLCK_C = 4'(UNLOCK_ERR);
  logic [WORD_W-1:0] word, exp_w, ref_q, ref_d;
  logic [3:0] good_q, good_d, bad_q, bad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  state_e state_q, state_d;
  logic a_q, locked_q, locked_d, err_q, err_d, match;
  assign word    = {w, x, y, z};
  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;
  always_comb begin
    exp_w   = gray_step(ref_q, A);
    match   = word == exp_w;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    state_d = state_q;
    ref_d   = ref_q;
    good_d  = good_q;
    bad_d   = bad_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (A != a_q) begin
      ref_d   = word;
      good_d  = '0;
      bad_d   = '0;
      state_d = TRACK;
    end else begin
      case (state_q)
        HUNT: begin
          ref_d   = word;
          good_d  = '0;
          bad_d   = '0;
          state_d = TRACK;
        end
        TRACK: begin
          ref_d   = word;
          good_d  = match ? good_q + 4'd1 : 4'd0;
          state_d = (match && good_q + 4'd1 == LOCK_C) ? LOCKED : TRACK;
        end
        LOCKED: begin
          // flywheel: once locked, the reference advances on its own so one bad word cannot derail it
          ref_d   = exp_w;
          err_d   = !match;
          cnt_d   = match ? cnt_q : cnt_inc;
          bad_d   = match ? bad_q : 4'd1;
          state_d = match ? LOCKED : (UNLCK_C == 4'd1 ? HUNT : SLIP);
        end
        SLIP: begin
          ref_d   = exp_w;
          err_d   = !match;
          cnt_d   = match ? cnt_q : cnt_inc;
          bad_d   = match ? 4'd0 : bad_q + 4'd1;
          state_d = match ? LOCKED : (bad_q + 4'd1 == UNLCK_C ? HUNT : SLIP);
        end
      endcase
    end
    locked_d = state_d == LOCKED || state_d == SLIP;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      ref_q    <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      a_q      <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      a_q      <= A;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_seq_check4bit.sv
// tb_seq_check4bit: scoreboard bench for seq_check4bit with a table-driven Gray model and a 2-bit-counter twin
module tb_seq_check4bit;
  import seq_gen_pkg::*;
  localparam int LOCK_CNT = 4, UNLOCK_ERR = 2;
  logic clk = 1'b0, rst_n = 1'b0, A = 1'b0, w = 1'b0, x = 1'b0, y = 1'b0, z = 1'b0;
  logic locked, err, locked2, err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  seq_check4bit #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .w(w), .x(x), .y(y), .z(z),
    .locked(locked), .err(err), .err_cnt(err_cnt));
  seq_check4bit #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .A(A), .w(w), .x(x), .y(y), .z(z),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2));
  always #5 clk = ~clk;
  typedef struct {logic locked; logic err; int cnt8; int cnt2;} exp_t;
  exp_t sb[$];
  logic [3:0] gseq [16];
  int n_chk = 0, n_err = 0, pos = 0;
  state_e m_state = HUNT;
  logic [3:0] m_ref = '0;
  int m_good = 0, m_bad = 0, m_cnt8 = 0, m_cnt2 = 0;
  logic m_a = 1'b0;
  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, want, $time);
    end
  endtask
  function automatic logic [3:0] m_next(input logic [3:0] r, input logic dir);
    int idx = 0;
    for (int i = 0; i < 16; i++) if (gseq[i] == r) idx = i;
    return gseq[dir ? (idx + 15) % 16 : (idx + 1) % 16];
  endfunction
  task automatic m_err();
    m_cnt8 = m_cnt8 < 255 ? m_cnt8 + 1 : 255;
    m_cnt2 = m_cnt2 < 3 ? m_cnt2 + 1 : 3;
  endtask
  task automatic model(input logic [3:0] wd, input logic a, input logic rn, output exp_t e);
    logic [3:0] nx;
    e.err = 1'b0;
    if (!rn) begin
      m_state = HUNT; m_ref = '0; m_good = 0; m_bad = 0; m_a = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      nx = m_next(m_ref, a);
      if (a != m_a) begin
        m_ref = wd; m_good = 0; m_bad = 0; m_state = TRACK;
      end else if (m_state == HUNT) begin
        m_ref = wd; m_good = 0; m_state = TRACK;
      end else if (m_state == TRACK) begin
        m_ref = wd;
        if (wd == nx) begin
          m_good++;
          if (m_good == LOCK_CNT) m_state = LOCKED;
        end else m_good = 0;
      end else if (m_state == LOCKED) begin
        m_ref = nx;
        if (wd != nx) begin
          e.err = 1'b1; m_err(); m_bad = 1; m_state = SLIP;
        end
      end else begin
        m_ref = nx;
        if (wd == nx) begin
          m_bad = 0; m_state = LOCKED;
        end else begin
          e.err = 1'b1; m_err(); m_bad++;
          if (m_bad == UNLOCK_ERR) m_state = HUNT;
        end
      end
      m_a = a;
    end
    e.locked = m_state == LOCKED || m_state == SLIP;
    e.cnt8 = m_cnt8;
    e.cnt2 = m_cnt2;
  endtask
  task automatic drive(input logic [3:0] wd, input logic a, input logic rn);
    exp_t e;
    @(negedge clk);
    {w, x, y, z} = wd; A = a; rst_n = rn;
    model(wd, a, rn, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("locked", int'(locked), int'(e.locked));
    check("err", int'(err), int'(e.err));
    check("err_cnt", int'(err_cnt), e.cnt8);
    check("err_cnt_w2", int'(err_cnt2), e.cnt2);
  endtask
  task automatic run(input int n, input logic a);
    repeat (n) begin
      drive(gseq[pos], a, 1'b1);
      pos = a ? (pos + 15) % 16 : (pos + 1) % 16;
    end
  endtask
  task automatic bad(input logic a);
    drive(gseq[pos] ^ 4'b1111, a, 1'b1);
    pos = a ? (pos + 15) % 16 : (pos + 1) % 16;
  endtask
  initial begin
    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    drive(4'b0000, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    pos = 0;
    run(4, 1'b0);
    check("not_locked_yet", int'(locked), 0);
    run(1, 1'b0);
    check("lock_after_5", int'(locked), 1);
    run(13, 1'b0);
    drive(gseq[1], 1'b1, 1'b1);
    check("flip_drop", int'(locked), 0);
    pos = 0;
    run(20, 1'b1);
    drive(4'b0000, 1'b0, 1'b0);
    pos = 14;
    run(5, 1'b0);
    drive(4'b0110, 1'b0, 1'b1);
    check("glitch_err", int'(err), 1);
    pos = 4;
    run(3, 1'b0);
    bad(1'b0);
    bad(1'b0);
    check("unlock", int'(locked), 0);
    run(5, 1'b0);
    bad(1'b0); run(1, 1'b0);
    bad(1'b0); run(1, 1'b0);
    check("cnt5", int'(err_cnt), 5);
    check("cnt_w2_sat", int'(err_cnt2), 3);
    drive(gseq[(pos + 15) % 16], 1'b1, 1'b1);
    pos = (pos + 14) % 16;
    run(4, 1'b1);
    run(2, 1'b1);
    drive(4'b0000, 1'b1, 1'b0);
    check("rst_cnt", int'(err_cnt), 0);
    pos = 0;
    run(5, 1'b0);
    repeat (300) begin
      bad(1'b0);
      run(1, 1'b0);
    end
    check("cnt_sat", int'(err_cnt), 255);
    bad(1'b0);
    check("err_after_sat", int'(err), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/seq_check4bit.md
Name: seq_check4bit

Overview:
- Downstream consumer of the 4-bit sequence generator (seqGen4bit).
- Samples the generator's w x y z outputs every clock and checks each word against the expected successor for the current mode A.
- Achieves lock after a run of good transitions, flags and counts sequence errors, and drops lock after repeated errors.
- Used as the on-chip self-check and status source for the generator.

Parameters:
LOCK_CNT, 4, consecutive matching transitions needed to assert locked (1..15)
UNLOCK_ERR, 2, consecutive mismatches while locked that drop lock (1..15)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
A  input  1  mode: 0 = Gray count up, 1 = Gray count down (same signal that drives the generator)
w  input  1  sequence bit 3 (MSB)
x  input  1  sequence bit 2
y  input  1  sequence bit 1
z  input  1  sequence bit 0 (LSB)
locked  output  1  checker is locked to the sequence
err  output  1  one-cycle pulse on a mismatch while locked
err_cnt  output  CNT_W  saturating count of err pulses

Behaviour:
- Clock and reset:
  - One clock: clk. Reset: synchronous, active-low rst_n, sampled on the rising edge.
  - Reset values: locked=0, err=0, err_cnt=0, state=HUNT, ref=0000, good_cnt=0, bad_cnt=0, a_q=0.
- Datapath:
  - word = {w,x,y,z}.
  - Generator contract: 4-bit reflected Gray code stepping once per clk.
  - Sequence: 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then wraps to 0000.
  - A=1 walks the same list backwards; 0000 is followed by 1000.
  - exp = gray_step(ref, A). gray_step converts Gray to binary, adds +1 or -1 mod 16, and converts back.
  - match = (word == exp).
- Outputs: all registered. Response appears the cycle after the word is sampled.
- Mode change:
  - If A != a_q, no compare that cycle and no err.
  - ref<=word, good_cnt<=0, bad_cnt<=0, state<=TRACK, so locked drops.
  - This rule has priority over all state rules.
  - a_q<=A every cycle.
- FSM transitions:
  - HUNT: ref<=word; go to TRACK with good_cnt=0.
  - TRACK: ref<=word.
    - match: good_cnt++. If good_cnt reaches LOCK_CNT, go to LOCKED.
    - mismatch: good_cnt<=0, stay in TRACK, no err.
  - LOCKED (flywheel): ref<=exp regardless of word.
    - match: stay.
    - mismatch: err=1, err_cnt++, bad_cnt<=1, go to SLIP. If UNLOCK_ERR==1, go to HUNT instead.
  - SLIP (flywheel): ref<=exp.
    - match: bad_cnt<=0, go to LOCKED.
    - mismatch: err=1, err_cnt++, bad_cnt++. If bad_cnt reaches UNLOCK_ERR, go to HUNT.
- locked = 1 in LOCKED or SLIP. It falls on the same edge that enters HUNT or TRACK.
- err_cnt:
  - Saturates at 2^CNT_W-1; err still pulses after saturation.
  - Cleared only by reset.
- Boundary cases:
  - Wrap 1000->0000 (up) and 0000->1000 (down) are legal transitions.
  - Reset asserted mid-lock clears everything on that edge; the first word after reset release is a HUNT seed.

Decomposition:
- Package seq_gen_pkg:
  - WORD_W=4.
  - State enum {HUNT, TRACK, LOCKED, SLIP}.
  - Functions gray2bin, bin2gray, gray_step(ref, dir).
  - The package is shared with the generator and the bench model.
- No sub-module. gray_step stays a package function. FSM and counters live in one module.

Test Plan:
1. Lock: reset 2 cycles, A=0, feed 0000,0001,0011,0010,0110 -> locked rises after 5th word sampled; err=0, err_cnt=0.
2. Wrap: locked, A=0, feed ...1011,1001,1000,0000,0001 -> locked stays 1, no err; repeat with A=1 through 0001,0000,1000,1001 -> no err.
3. Single glitch: locked with ref=0011, A=0:
   - feed 0110 (expected 0010) -> err pulse 1 cycle, err_cnt=1, locked stays 1;
   - next feed 0110 (flywheel expects 0110) -> match, state LOCKED, no err.
4. Unlock: locked, inject two consecutive wrong words -> err pulses twice, err_cnt=2, locked=0 after 2nd; then correct words -> locked after seed +4 matches; saturation: CNT_W=2, 5 errors -> err_cnt holds 3.
5. Mode flip: locked counting up at 0110, drive A=1 with word 0110 then 0010,0011,0001,0000 -> locked=0 for cycle after flip, no err, locked=1 after 4th down match.
6. Reset mid-operation: locked, err_cnt=5, assert rst_n=0 one edge -> locked=0, err=0, err_cnt=0 next cycle; release and relock per scenario 1.
